// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W data bits LSB first, then one parity bit.
// Reassembles the word, checks parity against a running XOR and aborts stalled frames.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; working registers held clear
// S_DATA   | shifting in data bits, accumulating parity
// S_PARITY | waiting for the parity bit to close the frame
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              frame_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_IDLE = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idle_q;
  logic                acc_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                parity_err_q;
  logic                frame_valid_q;
  logic                timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      acc_q         <= 1'b0;
      data_out_q    <= '0;
      parity_err_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          shift_q <= '0;
          cnt_q   <= '0;
          idle_q  <= '0;
          acc_q   <= 1'b0;
          if (start) state_q <= S_DATA;
        end

        S_DATA: begin
          if (bit_valid) begin
            shift_q <= {bit_in, shift_q[DATA_W-1:1]};
            acc_q   <= acc_q ^ bit_in;
            cnt_q   <= cnt_q + CW'(1);
            idle_q  <= '0;
            if (cnt_q == LAST_BIT) state_q <= S_PARITY;
          end else if (idle_q == LAST_IDLE) begin
            state_q       <= S_IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            idle_q <= idle_q + IW'(1);
          end
        end

        S_PARITY: begin
          if (bit_valid) begin
            data_out_q    <= shift_q;
            parity_err_q  <= acc_q ^ bit_in ^ ODD_PARITY;
            frame_valid_q <= 1'b1;
            idle_q        <= '0;
            state_q       <= S_IDLE;
          end else if (idle_q == LAST_IDLE) begin
            state_q       <= S_IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            idle_q <= idle_q + IW'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign parity_err  = parity_err_q;
  assign frame_valid = frame_valid_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Serial frame receiver with a running XOR parity accumulator. It sits directly downstream of the XOR/XNOR gate stage and chains that function over time. Each frame is DATA_W data bits, LSB first, followed by one parity bit. The block reassembles the data word, checks parity, flags errors, and aborts frames that stall.

## Interface
Parameters:
- DATA_W, 8, number of data bits per frame (≥2)
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected
- TIMEOUT, 16, consecutive idle cycles (bit_valid low) tolerated mid-frame before abort (≥1)

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous, active-high reset
- start, input, 1, frame start request; sampled only in IDLE
- bit_in, input, 1, serial data/parity bit
- bit_valid, input, 1, bit_in is valid this cycle
- data_out, output, DATA_W, last completed frame's data word
- parity_err, output, 1, parity result of last completed frame
- frame_valid, output, 1, one-cycle pulse when a frame completes
- timeout_err, output, 1, one-cycle pulse when a frame is aborted by timeout
- busy, output, 1, high while a frame is in progress (state ≠ IDLE)

One clock; reset is synchronous and active-high.

## Operation
- The FSM has three states: IDLE, DATA and PARITY.
- **IDLE:**
  - start=1 moves to DATA.
  - It clears the shift register, the bit counter, the parity accumulator and the idle counter.
  - bit_valid is ignored.
- **DATA:**
  - Each cycle with bit_valid=1 does three things:
    - shifts bit_in into the shift register MSB-side, so after DATA_W bits the first bit received sits at bit 0;
    - updates acc ← acc ^ bit_in;
    - increments the bit counter.
  - After the DATA_W-th valid bit, the FSM moves to PARITY.
- **PARITY:**
  - The first cycle with bit_valid=1 samples the parity bit p.
  - On that edge: data_out ← shift register; parity_err ← acc ^ p ^ ODD_PARITY; frame_valid ← 1 for one cycle; FSM → IDLE.
- **start while busy:** ignored. No restart and no effect.
- **Idle counter:**
  - Active in DATA and PARITY; counts consecutive cycles with bit_valid=0 and resets to 0 on any bit_valid=1.
  - The start-accept cycle is not counted.
  - When the TIMEOUT-th consecutive idle cycle is sampled:
    - FSM → IDLE and timeout_err pulses for one cycle;
    - data_out and parity_err keep their previous values;
    - frame_valid stays 0.
- **Reset:**
  - rst=1 at an edge wins over everything, including mid-frame. The FSM returns to IDLE and the internal registers clear.
  - All outputs are 0 after reset: data_out=0, parity_err=0, frame_valid=0, timeout_err=0, busy=0.
- **Hold behaviour:** data_out and parity_err hold until the next completed frame or reset.
- **Width rules:** the bit counter is clog2(DATA_W+1) bits; the idle counter is clog2(TIMEOUT+1) bits. Neither counter may wrap.

## Timing
- start sampled at edge E0 → busy=1 from E0 until FSM returns to IDLE.
- The first data bit can be sampled at edge E1.
- With back-to-back bits, the minimum frame is DATA_W+1 bit cycles after the start cycle.
- Completion is registered on the parity-sampling edge. frame_valid, data_out and parity_err all update on that same edge, and busy=0 in the same cycle.
- Latency from the parity bit to frame_valid is 1 edge (the registered output).
- A new start is accepted in the cycle frame_valid is high, because the FSM is already in IDLE.
- Timeout fires at the edge sampling the TIMEOUT-th idle cycle. timeout_err is high for the following cycle and busy=0 in that same cycle.
- If bit_valid=1 arrives on the cycle that would have been the TIMEOUT-th idle cycle, it is a valid bit: no timeout, and the bit is accepted.
- frame_valid and timeout_err are never high together.

## Test plan
1. **Reset.** Hold rst=1 for 2 cycles with random inputs → data_out=0x00, parity_err=0, frame_valid=0, timeout_err=0, busy=0.
2. **Clean frame.** start, then bits 1,0,1,0,0,1,0,1 back-to-back, then parity 0 (even, 4 ones) → exactly one frame_valid pulse, data_out=0xA5, parity_err=0, busy falls the same cycle.
3. **Parity error.** Same frame with parity bit 1 → data_out=0xA5, parity_err=1. With ODD_PARITY=1, parity 1 → parity_err=0.
4. **Gapped bits.** 0x3C with bit_valid low for 3 cycles between every bit, parity 0 → no timeout, data_out=0x3C, parity_err=0. A start pulse mid-frame has no effect.
5. **Timeout.** After a prior 0xA5 frame: start, 3 valid bits, then bit_valid low for 16 cycles → timeout_err pulses once at the 16th idle edge, busy=0, data_out stays 0xA5, no frame_valid. A bit arriving at idle count 15 instead → no timeout.
6. **Reset mid-frame and IDLE input.** rst pulsed after 4 data bits → next cycle busy=0 and all outputs 0. bit_valid pulses in IDLE without start → no state change. start in the frame_valid cycle → new frame accepted.
